// File: rtl/gate_pkg.sv
// Shared gate mode codes, sweep FSM encoding and mode legality helper
package gate_pkg;

    localparam logic [2:0] MODE_OR   = 3'd0;
    localparam logic [2:0] MODE_NOR  = 3'd1;
    localparam logic [2:0] MODE_AND  = 3'd2;
    localparam logic [2:0] MODE_NAND = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_e;

    function automatic logic is_legal_mode(input logic [2:0] m);
        return (m <= MODE_XNOR);
    endfunction

endpackage

// File: rtl/gate_truth_sweep_if.sv
// Sweep control/result bundle between the sweep engine and its consumer
interface gate_truth_sweep_if #(
    parameter int unsigned N = 3
);
    localparam int unsigned ROWS = 32'd1 << N;

    logic            start;
    logic            busy;
    logic [N-1:0]    x_drv;
    logic            sample_valid;
    logic [N-1:0]    sample_idx;
    logic            sample_y;
    logic [ROWS-1:0] result;
    logic [N:0]      ones_count;
    logic            done;
    logic            err;

    modport master (
        output start,
        input  busy, x_drv, sample_valid, sample_idx, sample_y,
        input  result, ones_count, done, err
    );

    modport slave (
        input  start,
        output busy, x_drv, sample_valid, sample_idx, sample_y,
        output result, ones_count, done, err
    );

endinterface

// File: rtl/gate_reduce.sv
// Combinational N-input reduction gate selected by mode; illegal modes give 0
module gate_reduce
    import gate_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] x,
    input  logic [2:0]   mode,
    output logic         y,
    output logic         illegal
);

    always_comb begin
        y       = 1'b0;
        illegal = !is_legal_mode(mode);
        case (mode)
            MODE_OR:   y = |x;
            MODE_NOR:  y = ~|x;
            MODE_AND:  y = &x;
            MODE_NAND: y = ~&x;
            MODE_XOR:  y = ^x;
            MODE_XNOR: y = ~^x;
            default:   y = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_truth_sweep.sv
// Reduction gate with registered direct path and an exhaustive truth-table sweep engine
module gate_truth_sweep
    import gate_pkg::*;
#(
    parameter int unsigned N      = 3,
    parameter int unsigned SETTLE = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         mode,
    input  logic [N-1:0]       x_in,
    output logic               y_direct,
    gate_truth_sweep_if.slave  sw
);

    localparam int unsigned ROWS  = 32'd1 << N;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned OC_W  = N + 1;

    state_e          state_q, state_d;
    logic [2:0]      mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]    x_drv_q, x_drv_d;
    logic            y_direct_q, y_direct_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [N-1:0]    idx_q, idx_d;
    logic            sy_q, sy_d;
    logic [ROWS-1:0] result_q, result_d;
    logic [N:0]      ones_q, ones_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic y_dir_c, ill_dir_c, y_swp_c, ill_swp_c;

    gate_reduce #(.N(N)) u_direct (.x(x_in),    .mode(mode),   .y(y_dir_c), .illegal(ill_dir_c));
    gate_reduce #(.N(N)) u_sweep  (.x(x_drv_q), .mode(mode_q), .y(y_swp_c), .illegal(ill_swp_c));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            cnt_q      <= '0;
            x_drv_q    <= '0;
            y_direct_q <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            idx_q      <= '0;
            sy_q       <= 1'b0;
            result_q   <= '0;
            ones_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            x_drv_q    <= x_drv_d;
            y_direct_q <= y_direct_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            idx_q      <= idx_d;
            sy_q       <= sy_d;
            result_q   <= result_d;
            ones_q     <= ones_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Sweep sequencing: each row is held SETTLE cycles, then sampled for one
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        x_drv_d    = x_drv_q;
        y_direct_d = y_dir_c;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        idx_d      = idx_q;
        sy_d       = sy_q;
        result_d   = result_q;
        ones_d     = ones_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (sw.start) begin
                    mode_d   = mode;
                    result_d = '0;
                    ones_d   = '0;
                    cnt_d    = '0;
                    x_drv_d  = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                result_d[x_drv_q] = y_swp_c;
                sy_d    = y_swp_c;
                idx_d   = x_drv_q;
                valid_d = 1'b1;
                ones_d  = ones_q + OC_W'(y_swp_c);
                if (&x_drv_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    x_drv_d = x_drv_q + N'(1);
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A legal start clears the sticky error; any illegal mode in use sets it
        if (state_q == ST_IDLE && sw.start) begin
            err_d = ill_dir_c;
        end else if (ill_dir_c || (state_q != ST_IDLE && ill_swp_c)) begin
            err_d = 1'b1;
        end
    end

    assign y_direct        = y_direct_q;
    assign sw.busy         = busy_q;
    assign sw.x_drv        = x_drv_q;
    assign sw.sample_valid = valid_q;
    assign sw.sample_idx   = idx_q;
    assign sw.sample_y     = sy_q;
    assign sw.result       = result_q;
    assign sw.ones_count   = ones_q;
    assign sw.done         = done_q;
    assign sw.err          = err_q;

endmodule

// File: tb/tb_gate_truth_sweep.sv
// Randomised self-checking bench for gate_truth_sweep against a cycle-count reference model
module tb_gate_truth_sweep;

    localparam int unsigned N       = 3;
    localparam int unsigned S       = 5;
    localparam int unsigned ROWS    = 8;
    localparam int unsigned ROW_CYC = S + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [2:0]   mode;
    logic [N-1:0] x_in;
    logic         y_direct;
    gate_truth_sweep_if #(.N(N)) sw ();

    gate_truth_sweep #(.N(N), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .mode(mode), .x_in(x_in), .y_direct(y_direct), .sw(sw)
    );

    logic [2:0] mode1;
    logic [0:0] x1;
    logic       y1;
    gate_truth_sweep_if #(.N(1)) sw1 ();
    gate_truth_sweep #(.N(1), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .mode(mode1), .x_in(x1), .y_direct(y1), .sw(sw1)
    );

    logic [2:0] mode8;
    logic [7:0] x8;
    logic       y8;
    gate_truth_sweep_if #(.N(8)) sw8 ();
    gate_truth_sweep #(.N(8), .SETTLE(1)) dut8 (
        .clk(clk), .rst(rst), .mode(mode8), .x_in(x8), .y_direct(y8), .sw(sw8)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Gate truth from counting ones in the input code
    function automatic logic f_model(input int n, input int md, input int code);
        int  ones;
        logic all;
        ones = $countones(code);
        all  = (code == (1 << n) - 1);
        case (md)
            0: return code != 0;
            1: return code == 0;
            2: return all;
            3: return !all;
            4: return (ones % 2) == 1;
            5: return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: timeline of a sweep measured in edges since the start edge
    int           m_active, m_k, m_mode, m_row;
    logic         m_fy;
    logic         e_y, e_busy, e_valid, e_sy, e_done, e_err;
    logic [N-1:0] e_xdrv, e_idx;
    logic [ROWS-1:0] e_res;
    int           e_ones;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_k = 0;
            e_y = 0; e_busy = 0; e_xdrv = 0; e_valid = 0; e_idx = 0; e_sy = 0;
            e_res = 0; e_ones = 0; e_done = 0; e_err = 0;
        end else begin
            e_y = f_model(N, int'(mode), int'(x_in));
            if (m_active == 0 && sw.start) e_err = (mode > 3'd5);
            else if (mode > 3'd5) e_err = 1'b1;
            e_valid = 0;
            e_done  = 0;
            if (m_active != 0) begin
                m_k++;
                if (m_k % ROW_CYC == 0) begin
                    m_row = m_k / ROW_CYC - 1;
                    m_fy  = f_model(N, m_mode, m_row);
                    e_valid = 1;
                    e_idx   = N'(m_row);
                    e_sy    = m_fy;
                    e_res[m_row] = m_fy;
                    e_ones += int'(m_fy);
                    if (m_row == ROWS - 1) begin
                        e_done = 1; e_busy = 0; m_active = 0;
                    end else begin
                        e_xdrv = N'(m_row + 1);
                    end
                end
            end else if (sw.start) begin
                m_active = 1; m_k = 0; m_mode = int'(mode);
                e_res = 0; e_ones = 0; e_xdrv = 0; e_busy = 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("y_direct",     32'(y_direct),        32'(e_y));
        check("busy",         32'(sw.busy),         32'(e_busy));
        check("x_drv",        32'(sw.x_drv),        32'(e_xdrv));
        check("sample_valid", 32'(sw.sample_valid), 32'(e_valid));
        check("sample_idx",   32'(sw.sample_idx),   32'(e_idx));
        check("sample_y",     32'(sw.sample_y),     32'(e_sy));
        check("result",       32'(sw.result),       32'(e_res));
        check("ones_count",   32'(sw.ones_count),   32'(e_ones));
        check("done",         32'(sw.done),         32'(e_done));
        check("err",          32'(sw.err),          32'(e_err));
    end

    task automatic drive_direct(input logic [2:0] m, input logic [N-1:0] x, input logic exp);
        @(negedge clk);
        mode = m; x_in = x;
        @(posedge clk); #1;
        check("direct_literal", 32'(y_direct), 32'(exp));
    endtask

    task automatic sweep(input logic [2:0] m, input bit rnd,
                         output int busy_cyc, output int dones, output int strobes);
        int guard;
        guard = 0; busy_cyc = 0; dones = 0; strobes = 0;
        @(negedge clk);
        sw.start = 1'b1; mode = m;
        while (guard < int'(ROWS * ROW_CYC) + 10) begin
            @(posedge clk); #1;
            guard++;
            if (sw.busy) busy_cyc++;
            if (sw.sample_valid) strobes++;
            if (sw.done) begin
                dones++;
                break;
            end
            @(negedge clk);
            sw.start = rnd && guard > 2 && guard < 30 && ($urandom_range(0, 2) == 0);
            x_in = N'($urandom);
            if (rnd) mode = 3'($urandom_range(0, 7));
        end
        check("sweep_done_seen", 32'(dones), 32'd1);
    endtask

    int bc, dn, st, n, bad;

    initial begin
        rst = 1'b1; mode = 3'd0; x_in = '0; sw.start = 1'b0;
        mode1 = 3'd0; x1 = '0; sw1.start = 1'b0;
        mode8 = 3'd0; x8 = '0; sw8.start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy",   32'(sw.busy),   32'd0);
        check("reset_result", 32'(sw.result), 32'd0);
        rst = 1'b0;

        drive_direct(3'd0, 3'b000, 1'b0);
        drive_direct(3'd0, 3'b100, 1'b1);
        drive_direct(3'd3, 3'b111, 1'b0);

        sweep(3'd0, 1'b0, bc, dn, st);
        check("or_busy_cycles", 32'(bc), 32'd48);
        check("or_strobes",     32'(st), 32'd8);
        check("or_result",      32'(sw.result), 32'hFE);
        check("or_ones",        32'(sw.ones_count), 32'd7);
        check("or_err",         32'(sw.err), 32'd0);

        sweep(3'd1, 1'b0, bc, dn, st);
        check("nor_result", 32'(sw.result), 32'h01);
        check("nor_ones",   32'(sw.ones_count), 32'd1);
        sweep(3'd4, 1'b0, bc, dn, st);
        check("xor_result", 32'(sw.result), 32'h96);
        check("xor_ones",   32'(sw.ones_count), 32'd4);
        sweep(3'd2, 1'b0, bc, dn, st);
        check("and_result", 32'(sw.result), 32'h80);
        check("and_ones",   32'(sw.ones_count), 32'd1);

        // Mode toggles and start re-pulses while busy must not disturb the sweep
        sweep(3'd2, 1'b1, bc, dn, st);
        check("mid_result", 32'(sw.result), 32'h80);
        check("mid_strobes", 32'(st), 32'd8);
        @(negedge clk); mode = 3'd0;
        repeat (2) @(negedge clk);

        sw.start = 1'b1; mode = 3'd0;
        @(negedge clk); sw.start = 1'b0;
        repeat (5 * ROW_CYC) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy",   32'(sw.busy), 32'd0);
        check("abort_result", 32'(sw.result), 32'd0);
        check("abort_ones",   32'(sw.ones_count), 32'd0);
        @(negedge clk); rst = 1'b0;
        dn = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (sw.done) dn++;
        end
        check("abort_no_done", 32'(dn), 32'd0);

        sweep(3'd6, 1'b0, bc, dn, st);
        check("illegal_err",    32'(sw.err), 32'd1);
        check("illegal_result", 32'(sw.result), 32'd0);
        check("illegal_ones",   32'(sw.ones_count), 32'd0);
        sweep(3'd0, 1'b0, bc, dn, st);
        check("err_cleared",  32'(sw.err), 32'd0);
        check("after_result", 32'(sw.result), 32'hFE);

        for (int i = 0; i < 4; i++) begin
            sweep(3'($urandom_range(0, 7)), 1'b1, bc, dn, st);
        end
        @(negedge clk); sw.start = 1'b0;
        repeat (100) begin
            @(negedge clk);
            x_in = N'($urandom); mode = 3'($urandom_range(0, 7));
            sw.start = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk); sw.start = 1'b0;

        // N=1 corner
        @(negedge clk); mode1 = 3'd1; x1 = 1'b0; sw1.start = 1'b1;
        @(posedge clk); #1;
        check("c1_y_direct", 32'(y1), 32'd1);
        @(negedge clk); sw1.start = 1'b0;
        n = 1;
        while (!sw1.done && n < 20) begin
            @(posedge clk); #1;
            if (!sw1.done) n++;
        end
        check("c1_done_latency", 32'(n), 32'd4);
        check("c1_result", 32'(sw1.result), 32'h1);
        check("c1_ones",   32'(sw1.ones_count), 32'd1);

        // N=8 corner
        @(negedge clk); mode8 = 3'd4; x8 = 8'h07; sw8.start = 1'b1;
        @(posedge clk); #1;
        check("c8_y_direct", 32'(y8), 32'd1);
        @(negedge clk); sw8.start = 1'b0;
        n = 1;
        while (!sw8.done && n < 700) begin
            @(posedge clk); #1;
            if (!sw8.done) n++;
        end
        check("c8_done_latency", 32'(n), 32'd512);
        check("c8_ones", 32'(sw8.ones_count), 32'd128);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (sw8.result[i] !== f_model(8, 4, i)) bad++;
        end
        check("c8_result_bits_wrong", 32'(bad), 32'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
